ham_encoder_tx: RTL
===================

// Module: ham_encoder_tx
// PURPOSE
//  Upstream stage of the Hamming(7,4) decoder. Accepts a 4-bit nibble on a valid/ready handshake
//  and encodes it to a 7-bit Hamming codeword. Presents the codeword in parallel on enc_ham_data
//  and serialises it on tx as a framed bit stream (start, 7 code bits, stop).
//  An optional single-bit error injector lets the decoder bench exercise its correction path.
// PARAMETERS
//  CLKS_PER_BIT  4  clock cycles per serial bit period; legal range >= 1
// PORTS
//  clk           in   1  system clock; all state updates on the rising edge
//  rst           in   1  asynchronous, active-high reset
//  data_in       in   4  nibble to encode, d3..d0 = data_in[3:0]
//  data_valid    in   1  data_in is valid this cycle
//  data_ready    out  1  block can accept a nibble; high only in IDLE
//  err_inject    in   1  sampled at accept: flip one codeword bit
//  err_pos       in   3  sampled at accept: Hamming position 1..7 to flip; 0 = no flip
//  enc_ham_data  out  7  codeword latched at accept, including any injected error
//  tx            out  1  serial line; idle level 1
//  tx_busy       out  1  high from START through STOP
//  frame_done    out  1  one-cycle pulse on the last cycle of STOP
// BEHAVIOUR
//  Codeword: bit[i-1] holds Hamming position i.
//   b0=p1, b1=p2, b2=d0, b3=p3, b4=d1, b5=d2, b6=d3
//   p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3
//  Reset (async, immediate): state=IDLE, tx=1, tx_busy=0, frame_done=0,
//   enc_ham_data=0, bit/cycle counters=0. While rst is high, data_ready=1 (the state is IDLE).
//  Accept: the handshake is data_valid && data_ready on a clk edge.
//   On that edge: encode the nibble, apply any injected error, load the shift register
//   and enc_ham_data, and move to START.
//  Error injection: if err_inject=1 and err_pos is 1..7, invert bit[err_pos-1].
//   If err_pos=0 or err_inject=0, no bit is changed.
//  Input stability: data_in, err_inject and err_pos are ignored outside the accept cycle.
//   data_valid while busy has no effect; no input is queued.
//  FSM (cycle counter counts 0..CLKS_PER_BIT-1 in every state except IDLE):
//   IDLE  tx=1, data_ready=1. Go to START on accept.
//   START tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//   DATA  tx=shift[0] for CLKS_PER_BIT cycles per bit, b0 first through b6.
//         Shift right after each bit; go to STOP after the 7th bit.
//   STOP  tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle; return to IDLE.
//  tx, tx_busy and frame_done are registered outputs.
//   tx_busy=1 exactly while the state is START, DATA or STOP.
//  Latency: the tx falling edge appears on the first edge after accept.
//   A frame lasts 9*CLKS_PER_BIT cycles. Minimum accept-to-accept spacing is 9*CLKS_PER_BIT+1 cycles.
//  enc_ham_data holds its value until the next accept or reset.
//  Reset mid-frame aborts the frame: tx returns to 1 at once, and no frame_done is issued.
//  Counters are sized $clog2(CLKS_PER_BIT+1) bits plus a 3-bit bit index.
//   They must not wrap within a state.
// TESTING
//  1 Reset: assert rst mid-DATA -> tx=1, tx_busy=0, data_ready=1, enc_ham_data=0 immediately.
//  2 Encode: data_in=4'b1011, err_inject=0 -> enc_ham_data=7'b1010101.
//    Also 4'h0 -> 7'b0000000, 4'hF -> 7'b1111111, 4'b0001 -> 7'b0000111.
//  3 Inject: data_in=4'b1011, err_inject=1, err_pos=7 -> enc_ham_data=7'b0010101.
//    With err_pos=0 -> 7'b1010101.
//  4 Serial, CLKS_PER_BIT=4, codeword 7'b1010101 -> tx = 0x4, then 1,0,1,0,1,0,1 (x4 each), then 1x4.
//    frame_done pulses 36 cycles after the accept edge.
//  5 Handshake: hold data_valid=1 continuously -> one accept every 37 cycles.
//    data_ready is low for the whole frame, and mid-frame data_in changes do not alter tx.
//  6 Loopback: feed enc_ham_data into ham_decoder for all 16 nibbles x err_pos 0..7.
//    Decoded data must equal data_in, and pos_error must equal err_pos.

Source files
------------

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with a framed serial transmitter.
// A nibble accepted on the valid/ready handshake is encoded, optionally
// corrupted in one bit position, and then sent LSB-first as
// start + 7 code bits + stop. Each bit lasts CLKS_PER_BIT clocks.
module ham_encoder_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       err_inject,
  input  logic [2:0] err_pos,
  output logic [6:0] enc_ham_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done,
  output logic [1:0] state_dbg
);

  // Handshake: a nibble transfers on a rising clk edge where data_valid and
  // data_ready are both high. data_ready is high only in IDLE and nothing is
  // queued, so data_valid in any other state is simply ignored.

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [6:0]    r_shift;
  logic [6:0]    r_enc;
  logic          r_tx;
  logic          r_busy;
  logic          r_frame_done;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [6:0]    w_shift_nxt;
  logic          w_accept;
  logic          w_cnt_last;
  logic [6:0]    w_code;
  logic [6:0]    w_err_mask;
  logic [6:0]    w_code_err;
  logic          w_p1;
  logic          w_p2;
  logic          w_p3;

  assign w_accept   = data_valid && data_ready;
  assign w_cnt_last = (r_cnt == LAST_CNT);

  // Parity and codeword layout: bit[i-1] carries Hamming position i.
  always_comb begin
    w_p1   = data_in[0] ^ data_in[1] ^ data_in[3];
    w_p2   = data_in[0] ^ data_in[2] ^ data_in[3];
    w_p3   = data_in[1] ^ data_in[2] ^ data_in[3];
    w_code = {data_in[3], data_in[2], data_in[1], w_p3, data_in[0], w_p2, w_p1};
  end

  // Single-bit error mask; position 0 means no corruption.
  always_comb begin
    w_err_mask = 7'd0;
    if (err_inject && (err_pos != 3'd0)) begin
      w_err_mask = 7'(7'd1 << (err_pos - 3'd1));
    end
    w_code_err = w_code ^ w_err_mask;
  end

  // Next-state logic for the frame sequencer, counters and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
          w_shift_nxt = w_code_err;
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[6:1]};
          if (r_bit == 3'd6) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = 3'd0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        if (w_cnt_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  // State, counters and registered outputs; outputs are derived from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 7'd0;
      r_enc        <= 7'd0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      if (w_accept) begin
        r_enc <= w_code_err;
      end
      case (w_state_nxt)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= w_shift_nxt[0];
        default: r_tx <= 1'b1;
      endcase
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_STOP) && (w_cnt_nxt == LAST_CNT);
    end
  end

  assign data_ready   = (r_state == S_IDLE);
  assign enc_ham_data = r_enc;
  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign frame_done   = r_frame_done;
  assign state_dbg    = r_state;

endmodule
